// File: rtl/pin_entry_encoder.sv
// Button-driven BCD code entry. Turns debounced inc/dec/next/enter pulses
// into an edited DIGITS-wide code and strobes trig for one cycle on commit.
// digitSel/blink drive the seven-segment display so the digit under edit flashes.
module pin_entry_encoder #(
    parameter int DIGITS         = 4,
    parameter int MAX_DIGIT      = 9,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  next,
    input  logic                  enter,
    output logic [4*DIGITS-1:0]   pinCode,
    output logic                  trig,
    output logic [DIGITS-1:0]     digitSel,
    output logic                  blink,
    output logic                  active
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [3:0]    DIG_MAX   = 4'(MAX_DIGIT);
    localparam logic [CW-1:0] CUR_MAX   = CW'(DIGITS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_CYCLES - 1);

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_pin;
    logic [CW-1:0]       r_cursor;
    logic [TW-1:0]       r_tmo_cnt;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink;
    logic                r_trig;
    logic                r_active;
    logic [DIGITS-1:0]   r_digit_sel;

    logic [1:0]          w_state_nxt;
    logic [4*DIGITS-1:0] w_pin_nxt;
    logic [CW-1:0]       w_cursor_nxt;
    logic [TW-1:0]       w_tmo_nxt;
    logic [BW-1:0]       w_blink_cnt_nxt;
    logic                w_blink_nxt;
    logic                w_next_act;
    logic                w_any;
    logic [3:0]          w_cur_digit;
    logic [DIGITS-1:0]   w_sel_nxt;

    // Wrap-around digit arithmetic; a digit never leaves 0..MAX_DIGIT.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= DIG_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? DIG_MAX : d - 4'd1;
    endfunction

    assign w_any       = inc | dec | next | enter;
    assign w_cur_digit = r_pin[4*r_cursor +: 4];

    // Next-state, code edit, timeout and blink decisions for the coming edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_pin_nxt       = r_pin;
        w_cursor_nxt    = r_cursor;
        w_tmo_nxt       = '0;
        w_next_act      = 1'b0;
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = 1'b1;
        w_sel_nxt       = '0;

        case (r_state)
            S_IDLE: begin
                // The waking pulse only opens a fresh entry; it is not applied.
                if (inc | dec | next) begin
                    w_state_nxt  = S_EDIT;
                    w_pin_nxt    = '0;
                    w_cursor_nxt = CUR_MAX;
                end
            end
            S_EDIT: begin
                if (enter) begin
                    w_state_nxt = S_COMMIT;
                end else if (next) begin
                    w_next_act   = 1'b1;
                    w_cursor_nxt = (r_cursor == '0) ? CUR_MAX : r_cursor - 1'b1;
                end else if (inc && dec) begin
                    // Conflicting edits cancel; still counts as activity below.
                    w_pin_nxt = r_pin;
                end else if (inc) begin
                    w_pin_nxt[4*r_cursor +: 4] = digit_inc(w_cur_digit);
                end else if (dec) begin
                    w_pin_nxt[4*r_cursor +: 4] = digit_dec(w_cur_digit);
                end

                if (w_any) begin
                    w_tmo_nxt = '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_pin_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Blink only runs while staying in EDIT; moving the cursor restarts it lit.
        if (r_state == S_EDIT && w_state_nxt == S_EDIT) begin
            if (w_next_act) begin
                w_blink_cnt_nxt = '0;
                w_blink_nxt     = 1'b1;
            end else if (r_blink_cnt == BLNK_LAST) begin
                w_blink_cnt_nxt = '0;
                w_blink_nxt     = ~r_blink;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                w_blink_nxt     = r_blink;
            end
        end

        if (w_state_nxt == S_EDIT) begin
            w_sel_nxt[w_cursor_nxt] = 1'b1;
        end
    end

    // State and registered outputs; outputs are computed from next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pin       <= '0;
            r_cursor    <= CUR_MAX;
            r_tmo_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
            r_trig      <= 1'b0;
            r_active    <= 1'b0;
            r_digit_sel <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pin       <= w_pin_nxt;
            r_cursor    <= w_cursor_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink     <= w_blink_nxt;
            r_trig      <= (w_state_nxt == S_COMMIT);
            r_active    <= (w_state_nxt == S_EDIT);
            r_digit_sel <= w_sel_nxt;
        end
    end

    assign pinCode  = r_pin;
    assign trig     = r_trig;
    assign digitSel = r_digit_sel;
    assign blink    = r_blink;
    assign active   = r_active;

endmodule

// File: tb/tb_pin_entry_encoder.sv
// Directed bench for pin_entry_encoder with short timeout/blink periods.
module tb_pin_entry_encoder;

    localparam int DIGITS = 4;

    logic                clk;
    logic                rst;
    logic                inc;
    logic                dec;
    logic                next;
    logic                enter;
    logic [4*DIGITS-1:0] pinCode;
    logic                trig;
    logic [DIGITS-1:0]   digitSel;
    logic                blink;
    logic                active;

    int n_chk;
    int n_pass;
    int trig_cnt;

    pin_entry_encoder #(
        .DIGITS        (DIGITS),
        .MAX_DIGIT     (9),
        .TIMEOUT_CYCLES(20),
        .BLINK_CYCLES  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .next    (next),
        .enter   (enter),
        .pinCode (pinCode),
        .trig    (trig),
        .digitSel(digitSel),
        .blink   (blink),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle that trig is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (trig) trig_cnt = trig_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One clock with the given buttons held, then release; returns 1 ns after the edge.
    task automatic step(input logic i, input logic d, input logic n, input logic e);
        inc = i; dec = d; next = n; enter = e;
        @(posedge clk);
        #1;
        inc = 1'b0; dec = 1'b0; next = 1'b0; enter = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; trig_cnt = 0;
        inc = 1'b0; dec = 1'b0; next = 1'b0; enter = 1'b0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pin",    32'(pinCode),  32'h0);
        chk("rst_trig",   32'(trig),     32'h0);
        chk("rst_sel",    32'(digitSel), 32'h0);
        chk("rst_blink",  32'(blink),    32'h1);
        chk("rst_active", 32'(active),   32'h0);
        rst = 1'b0;

        // enter alone in IDLE is ignored
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_enter_active", 32'(active), 32'h0);
        chk("idle_enter_trig",   32'(trig),   32'h0);

        // Basic entry: wake, inc x3, next, dec, enter -> 3900
        trig_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wake_active", 32'(active),   32'h1);
        chk("wake_sel",    32'(digitSel), 32'h8);
        chk("wake_pin",    32'(pinCode),  32'h0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("inc3_pin", 32'(pinCode), 32'h3000);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("next_sel", 32'(digitSel), 32'h4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dec_wrap_pin", 32'(pinCode), 32'h3900);
        chk("pre_enter_trig", 32'(trig), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("commit_trig", 32'(trig),    32'h1);
        chk("commit_pin",  32'(pinCode), 32'h3900);
        chk("commit_sel",  32'(digitSel), 32'h0);
        idle(1);
        chk("post_trig",   32'(trig),     32'h0);
        chk("post_active", 32'(active),   32'h0);
        chk("post_pin",    32'(pinCode),  32'h3900);
        idle(2);
        chk("trig_once", 32'(trig_cnt), 32'h1);

        // inc wraps 9 -> 0 ; next wraps cursor 0 -> 3
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wake_next_pin", 32'(pinCode),  32'h0);
        chk("wake_next_sel", 32'(digitSel), 32'h8);
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("inc9_pin", 32'(pinCode), 32'h9000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("inc10_pin", 32'(pinCode), 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("next3_sel", 32'(digitSel), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("next4_sel", 32'(digitSel), 32'h8);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Blink half-period of 4 cycles; next restarts it lit
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("blink_wake", 32'(blink), 32'h1);
        idle(3);
        chk("blink_hold", 32'(blink), 32'h1);
        idle(1);
        chk("blink_toggle", 32'(blink), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("blink_next", 32'(blink), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Timeout: wake, inc, 20 idle cycles
        trig_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_inc_pin", 32'(pinCode), 32'h1000);
        idle(19);
        chk("tmo_19_active", 32'(active), 32'h1);
        idle(1);
        chk("tmo_20_active", 32'(active),   32'h0);
        chk("tmo_pin",       32'(pinCode),  32'h0);
        chk("tmo_sel",       32'(digitSel), 32'h0);
        idle(2);
        chk("tmo_no_trig", 32'(trig_cnt), 32'h0);

        // enter+inc in the same cycle commits the unmodified code
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("enter_inc_trig", 32'(trig),    32'h1);
        chk("enter_inc_pin",  32'(pinCode), 32'h1000);
        idle(2);

        // inc+dec together: no change, but clears the timeout counter
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(15);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("incdec_pin", 32'(pinCode), 32'h1000);
        idle(15);
        chk("incdec_alive", 32'(active), 32'h1);
        idle(5);
        chk("incdec_tmo", 32'(active), 32'h0);

        // Reset mid-EDIT
        trig_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_pin", 32'(pinCode), 32'h3000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_pin",    32'(pinCode),  32'h0);
        chk("mid_rst_active", 32'(active),   32'h0);
        chk("mid_rst_sel",    32'(digitSel), 32'h0);
        chk("mid_rst_blink",  32'(blink),    32'h1);
        idle(2);
        chk("mid_rst_no_trig", 32'(trig_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
